keypad_matrix_scanner: RTL and testbench



---
 rtl/keypad_matrix_scanner_pkg.sv | 26 ++
 rtl/keypad_matrix_scanner_if.sv | 28 ++
 rtl/keypad_matrix_scanner_sync_2ff.sv | 25 ++
 rtl/keypad_matrix_scanner.sv | 122 ++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared keypad constants, scanner state encoding and key-index helpers.
// Imported by the scanner, its interface and anything decoding key_n.
package keypad_matrix_scanner_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam int KP_KEYS = KP_ROWS * KP_COLS;
    localparam int ROW_W   = 2;

    typedef enum logic [1:0] {
        ST_PARK   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_COMMIT = 2'd2
    } kp_state_e;

    // Bit position of key (r, c) inside key_n.
    function automatic int key_idx(int r, int c);
        return r * KP_COLS + c;
    endfunction

    // Active-low one-hot row drive for row index r.
    function automatic logic [KP_ROWS-1:0] row_drive(logic [ROW_W-1:0] r);
        return ~(KP_ROWS'(1) << r);
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Keypad scanner bus: scan enable, matrix row/column lines, key frame out.
// slave = scanner side, master = controller/board side.
interface keypad_matrix_scanner_if;
    import keypad_matrix_scanner_pkg::*;

    logic               scan_en;
    logic [KP_COLS-1:0] col_in;
    logic [KP_ROWS-1:0] row_out;
    logic [KP_KEYS-1:0] key_n;
    logic               frame_valid;

    modport slave (
        input  scan_en,
        input  col_in,
        output row_out,
        output key_n,
        output frame_valid
    );

    modport master (
        output scan_en,
        output col_in,
        input  row_out,
        input  key_n,
        input  frame_valid
    );

endinterface

// File: rtl/keypad_matrix_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, resets to all ones.
// Ports: clk, rstn (async low), d (async in), q (synchronized out).
module keypad_matrix_scanner_sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Idle column lines are pulled up, so all-ones is the safe reset value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad matrix scanner: drives rows low in turn, samples columns, commits frames.
// Ports: clk, rstn (async low), bus (scan_en, col_in, row_out, key_n, frame_valid).
module keypad_matrix_scanner
    import keypad_matrix_scanner_pkg::*;
#(
    parameter int SETTLE_CYCLES = 5000,
    parameter int CNT_W         = 13
) (
    input  logic                    clk,
    input  logic                    rstn,
    keypad_matrix_scanner_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(KP_ROWS - 1);

    kp_state_e          state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ROW_W-1:0]   row, row_n;
    logic [KP_KEYS-1:0] staging, stage_n;
    logic [KP_KEYS-1:0] keys_q, keys_n;
    logic [KP_ROWS-1:0] rows_q, rows_n;
    logic               fv_q, fv_n;
    logic [KP_COLS-1:0] col_sync;

    keypad_matrix_scanner_sync_2ff #(
        .W (KP_COLS)
    ) u_col_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (bus.col_in),
        .q    (col_sync)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_PARK;
            cnt     <= '0;
            row     <= '0;
            staging <= '1;
            keys_q  <= '1;
            rows_q  <= '1;
            fv_q    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            row     <= row_n;
            staging <= stage_n;
            keys_q  <= keys_n;
            rows_q  <= rows_n;
            fv_q    <= fv_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        row_n   = row;
        stage_n = staging;
        keys_n  = keys_q;
        fv_n    = 1'b0;
        unique case (state)
            ST_PARK: begin
                cnt_n = '0;
                row_n = '0;
                if (bus.scan_en) begin
                    state_n = ST_DRIVE;
                end else begin
                    keys_n  = '1;
                    stage_n = '1;
                end
            end
            ST_DRIVE: begin
                if (!bus.scan_en) begin
                    state_n = ST_PARK;
                    cnt_n   = '0;
                    row_n   = '0;
                    keys_n  = '1;
                    stage_n = '1;
                end else if (cnt == CNT_LAST) begin
                    // Columns are sampled only in the last cycle of a slot.
                    stage_n[key_idx(int'(row), 0) +: KP_COLS] = col_sync;
                    cnt_n = '0;
                    if (row == ROW_LAST) begin
                        state_n = ST_COMMIT;
                    end else begin
                        row_n = row + ROW_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                // A frame completed here is always published, even if
                // scan_en dropped in this same cycle.
                keys_n = staging;
                fv_n   = 1'b1;
                cnt_n  = '0;
                row_n  = '0;
                if (bus.scan_en) begin
                    state_n = ST_DRIVE;
                end else begin
                    state_n = ST_PARK;
                    stage_n = '1;
                end
            end
            default: begin
                state_n = ST_PARK;
                cnt_n   = '0;
                row_n   = '0;
            end
        endcase
        // Row pins are registered from next state so they never glitch;
        // old row releases in the same edge the new row goes low.
        rows_n = (state_n == ST_DRIVE) ? row_drive(row_n) : '1;
    end

    assign bus.row_out     = rows_q;
    assign bus.key_n       = keys_q;
    assign bus.frame_valid = fv_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner with a resistive-short keypad model.
// SETTLE_CYCLES=8, frame period 33 cycles; expected frames kept in a queue.
module tb_keypad_matrix_scanner;
    import keypad_matrix_scanner_pkg::*;

    localparam int SETTLE = 8;
    localparam int FRAME  = KP_ROWS * SETTLE + 1;

    logic               clk  = 1'b0;
    logic               rstn = 1'b0;
    logic [KP_KEYS-1:0] keys = '0;
    logic [KP_COLS-1:0] col_model;
    logic [KP_KEYS-1:0] exp_q[$];
    int                 errors = 0;
    int                 checks = 0;
    logic               fv_prev = 1'b0;

    keypad_matrix_scanner_if kif ();

    keypad_matrix_scanner #(
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (kif)
    );

    always #5 clk = ~clk;

    // Closed key (r,c) shorts row r to column c; columns pulled up.
    always_comb begin
        col_model = '1;
        for (int r = 0; r < KP_ROWS; r++)
            for (int c = 0; c < KP_COLS; c++)
                if (!kif.row_out[r] && keys[r*KP_COLS+c])
                    col_model[c] = 1'b0;
    end
    assign kif.col_in = col_model;

    always @(negedge clk) begin
        checks += 2;
        if ($countones(~kif.row_out) > 1) begin
            errors++;
            $display("FAIL row_onehot row_out=%h required at most one low", kif.row_out);
        end
        if (kif.frame_valid && fv_prev) begin
            errors++;
            $display("FAIL fv_pulse frame_valid high two cycles, required single pulse");
        end
        fv_prev = kif.frame_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_fv(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!kif.frame_valid && n < 200);
        if (!kif.frame_valid) begin
            errors++;
            checks++;
            $display("FAIL fv_timeout no frame_valid within %0d cycles", n);
            n = -1;
        end
    endtask

    task automatic wait_row(input logic [KP_ROWS-1:0] r);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (kif.row_out !== r && n < 100);
        checks++;
        if (kif.row_out !== r) begin
            errors++;
            $display("FAIL row_wait row_out=%h required %h", kif.row_out, r);
        end
    endtask

    task automatic test_reset();
        logic [KP_ROWS-1:0] er;
        logic [KP_KEYS-1:0] ek;
        bit ok;
        int n;
        rstn = 1'b0;
        kif.scan_en = 1'b1;
        keys = '0;
        repeat (3) @(negedge clk);
        checks += 3;
        if (kif.row_out !== 4'hF) begin
            errors++;
            $display("FAIL rst_row row_out=%h required F", kif.row_out);
        end
        if (kif.key_n !== 16'hFFFF) begin
            errors++;
            $display("FAIL rst_key key_n=%h required FFFF", kif.key_n);
        end
        if (kif.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_fv frame_valid=%b required 0", kif.frame_valid);
        end
        rstn = 1'b1;
        for (int i = 0; i < KP_ROWS; i++) begin
            er = ~(4'b0001 << i);
            ok = 1'b1;
            repeat (SETTLE) begin
                @(negedge clk);
                if (kif.row_out !== er) ok = 1'b0;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL row_seq row %0d last row_out=%h required %h", i, kif.row_out, er);
            end
        end
        @(negedge clk);
        checks++;
        if (kif.row_out !== 4'hF) begin
            errors++;
            $display("FAIL commit_row row_out=%h required F", kif.row_out);
        end
        exp_q.push_back(16'hFFFF);
        wait_fv(n);
        checks += 2;
        if (KP_ROWS * SETTLE + 1 + n - 1 != FRAME + n - 1 || n != 1) begin
            errors++;
            $display("FAIL first_fv latency %0d required %0d", KP_ROWS * SETTLE + n, FRAME);
        end
        ek = exp_q.pop_front();
        if (kif.key_n !== ek) begin
            errors++;
            $display("FAIL first_frame key_n=%h required %h", kif.key_n, ek);
        end
    endtask

    task automatic test_no_keys();
        logic [KP_KEYS-1:0] ek;
        int n;
        keys = '0;
        repeat (2) begin
            exp_q.push_back(16'hFFFF);
            wait_fv(n);
            ek = exp_q.pop_front();
            checks += 2;
            if (n != FRAME) begin
                errors++;
                $display("FAIL idle_period %0d required %0d", n, FRAME);
            end
            if (kif.key_n !== ek) begin
                errors++;
                $display("FAIL idle_key key_n=%h required %h", kif.key_n, ek);
            end
        end
    endtask

    task automatic test_single_key();
        logic [KP_KEYS-1:0] ek;
        int n;
        keys = 16'h0200;
        wait_fv(n);
        repeat (2) begin
            exp_q.push_back(16'hFDFF);
            wait_fv(n);
            ek = exp_q.pop_front();
            checks += 2;
            if (n != FRAME) begin
                errors++;
                $display("FAIL k21_period %0d required %0d", n, FRAME);
            end
            if (kif.key_n !== ek) begin
                errors++;
                $display("FAIL k21_key key_n=%h required %h", kif.key_n, ek);
            end
        end
        keys = '0;
        wait_fv(n);
        exp_q.push_back(16'hFFFF);
        wait_fv(n);
        ek = exp_q.pop_front();
        checks++;
        if (kif.key_n !== ek) begin
            errors++;
            $display("FAIL k21_release key_n=%h required %h", kif.key_n, ek);
        end
    endtask

    task automatic test_multi_key();
        logic [KP_KEYS-1:0] ek;
        int n;
        keys = 16'h1001;
        wait_fv(n);
        exp_q.push_back(16'hEFFE);
        wait_fv(n);
        ek = exp_q.pop_front();
        checks++;
        if (kif.key_n !== ek) begin
            errors++;
            $display("FAIL multi_key key_n=%h required %h", kif.key_n, ek);
        end
        // Key (1,2) closes only in the last two cycles of row 1.
        exp_q.push_back(16'hEFFE);
        wait_row(4'hD);
        repeat (6) @(negedge clk);
        keys = 16'h1041;
        wait_row(4'hB);
        keys = 16'h1001;
        wait_fv(n);
        ek = exp_q.pop_front();
        checks++;
        if (kif.key_n !== ek) begin
            errors++;
            $display("FAIL late_key key_n=%h required %h", kif.key_n, ek);
        end
    endtask

    task automatic test_commit_drop();
        logic [KP_KEYS-1:0] ek;
        exp_q.push_back(16'hEFFE);
        wait_row(4'hF);
        kif.scan_en = 1'b0;
        @(negedge clk);
        ek = exp_q.pop_front();
        checks += 2;
        if (kif.frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL drop_fv frame_valid=%b required 1", kif.frame_valid);
        end
        if (kif.key_n !== ek) begin
            errors++;
            $display("FAIL drop_key key_n=%h required %h", kif.key_n, ek);
        end
        @(negedge clk);
        checks += 3;
        if (kif.row_out !== 4'hF) begin
            errors++;
            $display("FAIL drop_park_row row_out=%h required F", kif.row_out);
        end
        if (kif.key_n !== 16'hFFFF) begin
            errors++;
            $display("FAIL drop_park_key key_n=%h required FFFF", kif.key_n);
        end
        if (kif.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_park_fv frame_valid=%b required 0", kif.frame_valid);
        end
        repeat (3) @(negedge clk);
        kif.scan_en = 1'b1;
    endtask

    task automatic test_disable();
        logic [KP_KEYS-1:0] ek;
        bit seen;
        int n;
        wait_row(4'hB);
        kif.scan_en = 1'b0;
        @(negedge clk);
        checks += 3;
        if (kif.row_out !== 4'hF) begin
            errors++;
            $display("FAIL dis_row row_out=%h required F", kif.row_out);
        end
        if (kif.key_n !== 16'hFFFF) begin
            errors++;
            $display("FAIL dis_key key_n=%h required FFFF", kif.key_n);
        end
        if (kif.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL dis_fv frame_valid=%b required 0", kif.frame_valid);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (kif.frame_valid || kif.row_out !== 4'hF) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL park_idle activity while parked, required none");
        end
        kif.scan_en = 1'b1;
        @(negedge clk);
        checks++;
        if (kif.row_out !== 4'hE) begin
            errors++;
            $display("FAIL reen_row row_out=%h required E", kif.row_out);
        end
        exp_q.push_back(16'hEFFE);
        wait_fv(n);
        ek = exp_q.pop_front();
        checks += 2;
        if (n != FRAME) begin
            errors++;
            $display("FAIL reen_latency %0d required %0d", n, FRAME);
        end
        if (kif.key_n !== ek) begin
            errors++;
            $display("FAIL reen_key key_n=%h required %h", kif.key_n, ek);
        end
    endtask

    task automatic test_reset_mid();
        logic [KP_KEYS-1:0] ek;
        int n;
        keys = 16'h0080;
        wait_row(4'h7);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checks += 3;
        if (kif.row_out !== 4'hF) begin
            errors++;
            $display("FAIL arst_row row_out=%h required F", kif.row_out);
        end
        if (kif.key_n !== 16'hFFFF) begin
            errors++;
            $display("FAIL arst_key key_n=%h required FFFF", kif.key_n);
        end
        if (kif.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_fv frame_valid=%b required 0", kif.frame_valid);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (kif.row_out !== 4'hE) begin
            errors++;
            $display("FAIL arst_restart row_out=%h required E", kif.row_out);
        end
        exp_q.push_back(16'hFF7F);
        wait_fv(n);
        ek = exp_q.pop_front();
        checks += 2;
        if (n != FRAME) begin
            errors++;
            $display("FAIL arst_latency %0d required %0d", n, FRAME);
        end
        if (kif.key_n !== ek) begin
            errors++;
            $display("FAIL arst_key_frame key_n=%h required %h", kif.key_n, ek);
        end
    endtask

    initial begin
        kif.scan_en = 1'b0;
        test_reset();
        test_no_keys();
        test_single_key();
        test_multi_key();
        test_commit_drop();
        test_disable();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
